// File: rtl/avr_int_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avr_int_pkg
// Purpose  : Shared types and vector arithmetic for the AVR-style interrupt
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package avr_int_pkg;

    localparam int VEC_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OFFER = 3'd1,
        ACK   = 3'd2,
        ISR   = 3'd3,
        HOLD  = 3'd4
    } int_state_e;

    // Slot 0 is the reset vector, so source idx lives in slot idx+1.
    function automatic logic [VEC_W-1:0] vec_addr(
        input logic [VEC_W-1:0] base,
        input logic [VEC_W-1:0] stride,
        input logic [VEC_W-1:0] idx
    );
        return base + ((idx + VEC_W'(1)) * stride);
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : int_prio_enc
// Purpose  : Combinational lowest-index-wins priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
module int_prio_enc #(
    parameter int N_SRC = 8,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    assign valid = |req;

    generate
        if (N_SRC == 1) begin : g_single
            assign idx = '0;
        end else begin : g_multi
            // Scanning downward lets the lowest set bit overwrite last.
            always_comb begin
                idx = '0;
                for (int i = N_SRC - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        idx = IDX_W'(i);
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/avr_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : avr_int_ctrl
// Purpose  : Priority interrupt controller with AVR no-nesting and
//            one-instruction-after-RETI semantics; all outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module avr_int_ctrl
    import avr_int_pkg::*;
#(
    parameter int          N_SRC      = 8,
    parameter logic [15:0] VEC_BASE   = 16'h0000,
    parameter int          VEC_STRIDE = 2,
    localparam int         SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_req,
    output logic [N_SRC-1:0] irq_ack,
    input  logic             sreg_i,
    output logic             int_pending,
    output logic [15:0]      int_vector,
    input  logic             cpu_int_take,
    input  logic             cpu_reti,
    input  logic             cpu_insn_retire,
    output logic             in_service,
    output logic [SRC_W-1:0] active_src
);

    localparam logic [VEC_W-1:0] STRIDE_V = VEC_W'(VEC_STRIDE);

    int_state_e       r_state;
    int_state_e       w_nstate;
    logic [SRC_W-1:0] r_sel;
    logic [SRC_W-1:0] w_nsel;
    logic [SRC_W-1:0] w_win_idx;
    logic             w_win_valid;
    logic [N_SRC-1:0] w_ack_mask;
    logic [N_SRC-1:0] r_ack;
    logic             r_pending;
    logic             r_in_service;
    logic [VEC_W-1:0] r_vector;

    int_prio_enc #(
        .N_SRC (N_SRC),
        .IDX_W (SRC_W)
    ) u_prio (
        .req   (irq_req),
        .valid (w_win_valid),
        .idx   (w_win_idx)
    );

    always_comb begin
        w_nstate = r_state;
        w_nsel   = r_sel;
        case (r_state)
            IDLE: begin
                if (sreg_i && w_win_valid) begin
                    w_nstate = OFFER;
                    w_nsel   = w_win_idx;
                end
            end
            OFFER: begin
                // A take freezes sel even if the request or SREG.I drops now.
                if (cpu_int_take) begin
                    w_nstate = ACK;
                end else if (!sreg_i || !w_win_valid) begin
                    w_nstate = IDLE;
                end else begin
                    w_nsel = w_win_idx;
                end
            end
            ACK: begin
                w_nstate = ISR;
            end
            ISR: begin
                if (cpu_reti) begin
                    w_nstate = cpu_insn_retire ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (cpu_insn_retire) begin
                    w_nstate = IDLE;
                end
            end
            default: begin
                w_nstate = IDLE;
            end
        endcase
    end

    always_comb begin
        w_ack_mask        = '0;
        w_ack_mask[r_sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sel        <= '0;
            r_ack        <= '0;
            r_pending    <= 1'b0;
            r_in_service <= 1'b0;
            r_vector     <= '0;
        end else begin
            r_state      <= w_nstate;
            r_sel        <= w_nsel;
            r_pending    <= (w_nstate == OFFER);
            r_in_service <= (w_nstate == ACK) || (w_nstate == ISR);
            r_ack        <= (w_nstate == ACK) ? w_ack_mask : '0;
            if (w_nstate == OFFER) begin
                r_vector <= vec_addr(VEC_BASE, STRIDE_V, VEC_W'(w_nsel));
            end
        end
    end

    assign irq_ack     = r_ack;
    assign int_pending = r_pending;
    assign int_vector  = r_vector;
    assign in_service  = r_in_service;

    generate
        if (N_SRC == 1) begin : g_src_one
            assign active_src = '0;
        end else begin : g_src_multi
            assign active_src = r_sel;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/avr_int_ctrl.md
# avr_int_ctrl

Priority interrupt controller sitting directly downstream of the timer/counter and the other AVR-style peripherals. It collects their level-sensitive interrupt requests, picks the highest-priority one, presents a vector to the CPU core, and returns the single-cycle `interrupt_executed` acknowledge that each peripheral uses to clear its flag. It also enforces AVR return semantics: no re-entry, and one main-program instruction retires after `RETI` before the next interrupt is taken.

## Interface
Parameters:
- `N_SRC`, 8: number of request sources; index 0 has the highest priority.
- `VEC_BASE`, 16'h0000: program-word address of vector slot 0 (the reset vector).
- `VEC_STRIDE`, 2: words between vector slots.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `irq_req`  in  N_SRC: level requests from peripherals (for example the timer's `interrupt_request`).
- `irq_ack`  out  N_SRC: one-hot, one-cycle acknowledge to the serviced source; wired to that peripheral's `interrupt_executed`.
- `sreg_i`  in  1: CPU global interrupt enable (SREG.I).
- `int_pending`  out  1: an interrupt is offered to the CPU.
- `int_vector`  out  16: vector address, valid while `int_pending`=1.
- `cpu_int_take`  in  1: pulse; CPU accepts the offered interrupt at an instruction boundary.
- `cpu_reti`  in  1: pulse; CPU executed RETI.
- `cpu_insn_retire`  in  1: pulse; CPU retired one instruction.
- `in_service`  out  1: an ISR is active.
- `active_src`  out  $clog2(N_SRC): index of the latched source.

## Operation
- States: IDLE, OFFER, ACK, ISR, HOLD. Reset forces IDLE.
- Reset values: `irq_ack`=0, `int_pending`=0, `int_vector`=0, `in_service`=0, `active_src`=0.
- Priority: the winner is the lowest set index of `irq_req`.
- Vector arithmetic: `int_vector` = `VEC_BASE` + (sel+1)·`VEC_STRIDE`, computed in 16 bits and wrapping mod 2^16.
- IDLE: if `sreg_i` and |`irq_req`, latch the winner into `sel` and go to OFFER.
- OFFER: `int_pending`=1.
  - Each cycle, re-arbitrate: a newly active lower index replaces `sel`.
  - If `sreg_i`=0 or `irq_req`=0, go to IDLE.
  - On `cpu_int_take`, go to ACK with `sel` frozen. Take wins over a simultaneous request drop or `sreg_i` drop.
- ACK: for one cycle, `irq_ack[sel]`=1, `int_pending`=0, `in_service`=1; then go to ISR.
- ISR: `in_service`=1. Requests are ignored regardless of `sreg_i` (no nesting). On `cpu_reti`, go to HOLD.
- HOLD: `in_service`=0 and no offer. On `cpu_insn_retire`, go to IDLE.
  - If `cpu_reti` and `cpu_insn_retire` arrive in the same cycle in ISR, the retire counts: go straight to IDLE.
- Ignored inputs:
  - `cpu_int_take` outside OFFER.
  - `cpu_reti` outside ISR.
  - `cpu_insn_retire` outside HOLD.
- Reset asserted in any state: IDLE on the next edge, all outputs at reset values, and no `irq_ack` pulse is emitted.
- N_SRC=1: `active_src` is 1 bit wide and tied to 0.

## Timing
- All outputs are registered.
- `irq_req`/`sreg_i` sampled high at edge k → `int_pending`=1 after edge k, i.e. one cycle of latency.
- A priority change during OFFER updates `int_vector` one cycle after the new request is sampled.
- `cpu_int_take` at edge t:
  - `irq_ack[sel]` high for exactly the cycle t..t+1;
  - `in_service` high from t onward;
  - `int_pending` low from t onward.
- The peripheral flag is cleared by the ack. If the peripheral's request is still high after ack, it is honoured only after the ISR → HOLD → IDLE sequence.
- Back-to-back interrupts: the minimum gap from `cpu_reti` to the next `int_pending` is 2 edges (retire, then IDLE arbitration).

## Structure
- Package `avr_int_pkg`:
  - `int_state_e` enum (IDLE, OFFER, ACK, ISR, HOLD);
  - `VEC_W`=16;
  - a function `vec_addr(base, stride, idx)`.
- Sub-module `int_prio_enc`: parameterised lowest-index priority encoder. Outputs `valid` and `idx` for an N_SRC-bit vector; purely combinational.
- The top level holds the FSM, the `sel` register and the output registers.

## Test plan
- `sreg_i`=1, `irq_req`=8'b0000_0100 → next cycle `int_pending`=1, `int_vector`=16'h0006; take → `irq_ack`=8'b0000_0100 for one cycle, then `in_service`=1.
- In OFFER with src 5 pending, raise src 1 → `int_vector` changes from 16'h000C to 16'h0004 one cycle later; take → ack on bit 1 only.
- `irq_req`=8'h80 with `sreg_i`=0 → `int_pending` stays 0. Raise `sreg_i` → pending next cycle with vector 16'h0010. Drop `irq_req` before take → IDLE, `int_pending`=0.
- In ISR, assert `irq_req`=8'h01 and pulse `cpu_reti`, then 3 idle cycles, then `cpu_insn_retire` → no offer until the cycle after retire, then `int_vector`=16'h0002.
- Assert `rst` during ACK, and separately during OFFER → no `irq_ack` pulse, all outputs 0, state IDLE.
- Same-cycle `cpu_int_take` and `irq_req` drop → ack still issued to the latched source.
